// File: rtl/noc_output_arbiter.sv
// Round-robin, packet-locked output arbiter: grants one input buffer per PKT_FLITS-flit packet.
// Optional stall abort is compiled in with the ARB_LOCK_TIMEOUT_EN macro.
module noc_output_arbiter #(
   parameter int NUM_PORTS  = 5,
   parameter int DATA_WIDTH = 16,
   parameter int PKT_FLITS  = 4,
   parameter int CNT_WIDTH  = 3,
   parameter int TIMEOUT    = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            buf_empty_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] buf_data_i,
   output logic [NUM_PORTS-1:0]            buf_read_o,
   input  logic                            out_ready_i,
   output logic                            out_valid_o,
   output logic [DATA_WIDTH-1:0]           out_data_o,
   output logic [NUM_PORTS-1:0]            grant_o,
   output logic                            busy_o,
   output logic                            abort_o
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                 state_reg, state_next;
   logic [PTR_W-1:0]       rr_ptr_reg, rr_ptr_next;
   logic [PTR_W-1:0]       gnt_idx_reg, gnt_idx_next;
   logic [NUM_PORTS-1:0]   grant_reg, grant_next;
   logic [CNT_WIDTH-1:0]   flit_cnt_reg, flit_cnt_next;
   logic                   out_valid_reg, out_valid_next;
   logic [DATA_WIDTH-1:0]  out_data_reg, out_data_next;

   logic [DATA_WIDTH-1:0]  head_data [NUM_PORTS];
   logic                   found;
   logic [PTR_W-1:0]       sel_idx;
   logic [PTR_W-1:0]       ptr_after_g;
   logic                   fire;
   logic                   last_flit;
   logic                   timeout_hit;
   int                     search_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
         assign head_data[gi] = buf_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Walk from the highest offset down so the port nearest rr_ptr wins.
   always_comb begin
      found      = 1'b0;
      sel_idx    = '0;
      search_idx = 0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         search_idx = int'(rr_ptr_reg) + k;
         if (search_idx >= NUM_PORTS) search_idx = search_idx - NUM_PORTS;
         if (!buf_empty_i[search_idx]) begin
            found   = 1'b1;
            sel_idx = PTR_W'(search_idx);
         end
      end
   end

   assign fire        = (state_reg == GRANT) && !buf_empty_i[gnt_idx_reg] && out_ready_i;
   assign last_flit   = (flit_cnt_reg == CNT_WIDTH'(PKT_FLITS - 1));
   assign ptr_after_g = (gnt_idx_reg == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx_reg + PTR_W'(1);

   // grant_reg is one-hot on the granted port, so masking it keeps reads a subset of grants.
   assign buf_read_o  = (fire && reset) ? grant_reg : '0;
   assign grant_o     = grant_reg;
   assign busy_o      = (state_reg == GRANT);
   assign out_valid_o = out_valid_reg;
   assign out_data_o  = out_data_reg;

`ifdef ARB_LOCK_TIMEOUT_EN
   localparam int ST_W = $clog2(TIMEOUT) + 1;

   logic [ST_W-1:0] stall_cnt_reg, stall_cnt_next;
   logic            abort_reg, abort_next;
   logic            stall;

   assign stall       = (state_reg == GRANT) && buf_empty_i[gnt_idx_reg] && out_ready_i;
   assign timeout_hit = stall && (stall_cnt_reg == ST_W'(TIMEOUT - 1));
   assign abort_o     = abort_reg;

   // Only cycles starved by an empty buffer count; downstream back-pressure holds the count.
   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      abort_next     = 1'b0;
      if (state_reg == IDLE) begin
         stall_cnt_next = '0;
      end else if (fire) begin
         stall_cnt_next = '0;
      end else if (timeout_hit) begin
         stall_cnt_next = '0;
         abort_next     = 1'b1;
      end else if (stall) begin
         stall_cnt_next = stall_cnt_reg + ST_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_reg <= '0;
         abort_reg     <= 1'b0;
      end else begin
         stall_cnt_reg <= stall_cnt_next;
         abort_reg     <= abort_next;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign abort_o     = 1'b0;
`endif

   always_comb begin
      state_next     = state_reg;
      rr_ptr_next    = rr_ptr_reg;
      gnt_idx_next   = gnt_idx_reg;
      grant_next     = grant_reg;
      flit_cnt_next  = flit_cnt_reg;
      out_valid_next = fire;
      out_data_next  = fire ? head_data[gnt_idx_reg] : out_data_reg;
      case (state_reg)
         IDLE: begin
            if (found) begin
               state_next    = GRANT;
               gnt_idx_next  = sel_idx;
               grant_next    = NUM_PORTS'(1) << sel_idx;
               flit_cnt_next = '0;
            end
         end
         GRANT: begin
            if (fire) begin
               if (last_flit) begin
                  state_next    = IDLE;
                  grant_next    = '0;
                  flit_cnt_next = '0;
                  rr_ptr_next   = ptr_after_g;
               end else begin
                  flit_cnt_next = flit_cnt_reg + CNT_WIDTH'(1);
               end
            end else if (timeout_hit) begin
               state_next    = IDLE;
               grant_next    = '0;
               flit_cnt_next = '0;
               rr_ptr_next   = ptr_after_g;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         gnt_idx_reg   <= '0;
         grant_reg     <= '0;
         flit_cnt_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         rr_ptr_reg    <= rr_ptr_next;
         gnt_idx_reg   <= gnt_idx_next;
         grant_reg     <= grant_next;
         flit_cnt_reg  <= flit_cnt_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
      end
   end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Scoreboard bench for noc_output_arbiter: directed packets, expected flits/grants queued, monitor compares.
module tb_noc_output_arbiter;

   localparam int N  = 5;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    buf_empty_i;
   logic [N*DW-1:0] buf_data_i;
   logic [N-1:0]    buf_read_o;
   logic            out_ready_i;
   logic            out_valid_o;
   logic [DW-1:0]   out_data_o;
   logic [N-1:0]    grant_o;
   logic            busy_o;
   logic            abort_o;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] exp_flits  [$];
   logic [N-1:0]  exp_grants [$];

   logic [DW-1:0] mem [N][16];
   int            wr_cnt [N] = '{default: 0};
   int            rd_cnt [N] = '{default: 0};
   bit            force_full = 1'b0;

   always #5 clk = ~clk;

   noc_output_arbiter #(
      .NUM_PORTS (N),
      .DATA_WIDTH(DW),
      .PKT_FLITS (4),
      .CNT_WIDTH (3),
      .TIMEOUT   (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .buf_empty_i(buf_empty_i),
      .buf_data_i (buf_data_i),
      .buf_read_o (buf_read_o),
      .out_ready_i(out_ready_i),
      .out_valid_o(out_valid_o),
      .out_data_o (out_data_o),
      .grant_o    (grant_o),
      .busy_o     (busy_o),
      .abort_o    (abort_o)
   );

   // Input buffer model: FIFO per port, head exposed combinationally, pointer advances on read strobe.
   always_comb begin
      buf_empty_i = '1;
      buf_data_i  = '0;
      for (int i = 0; i < N; i++) begin
         buf_empty_i[i]          = force_full ? 1'b0 : (rd_cnt[i] == wr_cnt[i]);
         buf_data_i[i*DW +: DW]  = force_full ? 16'hFFFF : mem[i][rd_cnt[i] % 16];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++)
         if (buf_read_o[i]) rd_cnt[i] <= rd_cnt[i] + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load(input int p, input int n, input logic [DW-1:0] base);
      for (int j = 0; j < n; j++) begin
         mem[p][wr_cnt[p] % 16] = base + DW'(j);
         wr_cnt[p]++;
      end
   endtask

   task automatic expect_pkt(input logic [DW-1:0] base, input int n);
      for (int j = 0; j < n; j++) exp_flits.push_back(base + DW'(j));
   endtask

   task automatic wait_idle(input string name);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(grant_o == '0 && exp_flits.size() == 0 && exp_grants.size() == 0) && cyc < 200);
      checks++;
      if (cyc >= 200) begin
         errors++;
         $display("FAIL %s: timed out, grant %b, %0d flits and %0d grants outstanding",
                  name, grant_o, exp_flits.size(), exp_grants.size());
         exp_flits.delete();
         exp_grants.delete();
      end
   endtask

   // Monitor: pops the scoreboard whenever a flit is presented or a new grant appears.
   initial begin
      logic [N-1:0]  prev_grant;
      logic [DW-1:0] ef;
      logic [N-1:0]  eg;
      prev_grant = '0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            if (out_valid_o) begin
               checks++;
               if (exp_flits.size() == 0) begin
                  errors++;
                  $display("FAIL flit: got %h expected none at %0t", out_data_o, $time);
               end else begin
                  ef = exp_flits.pop_front();
                  if (out_data_o !== ef) begin
                     errors++;
                     $display("FAIL flit: got %h expected %h at %0t", out_data_o, ef, $time);
                  end
               end
            end
            if (grant_o != prev_grant && grant_o != '0) begin
               checks++;
               if (exp_grants.size() == 0) begin
                  errors++;
                  $display("FAIL grant: got %b expected none at %0t", grant_o, $time);
               end else begin
                  eg = exp_grants.pop_front();
                  if (grant_o !== eg) begin
                     errors++;
                     $display("FAIL grant: got %b expected %b at %0t", grant_o, eg, $time);
                  end
               end
            end
         end
         prev_grant = grant_o;
      end
   end

   initial begin
      logic [N-1:0] eg;
      int           aborts;

      // Reset with every buffer presenting data and ready high.
      reset       = 1'b0;
      out_ready_i = 1'b1;
      force_full  = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_grant", grant_o, 0);
         check("rst_read", buf_read_o, 0);
         check("rst_valid", out_valid_o, 0);
         check("rst_data", out_data_o, 0);
         check("rst_busy", busy_o, 0);
         check("rst_abort", abort_o, 0);
      end
      force_full = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      check("idle_grant", grant_o, 0);
      check("idle_busy", busy_o, 0);

      // Single requester on port 2.
      load(2, 4, 16'hA000);
      exp_grants.push_back(5'b00100);
      expect_pkt(16'hA000, 4);
      @(negedge clk);
      check("p2_grant", grant_o, 5'b00100);
      check("p2_busy", busy_o, 1);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         check("p2_read", buf_read_o, 5'b00100);
      end
      @(negedge clk);
      check("p2_end_grant", grant_o, 0);
      check("p2_end_busy", busy_o, 0);
      check("p2_end_read", buf_read_o, 0);

      // rr_ptr is now 3: port 4 beats port 1, then port 1.
      load(1, 4, 16'hB100);
      load(4, 4, 16'hB400);
      exp_grants.push_back(5'b10000);
      exp_grants.push_back(5'b00010);
      expect_pkt(16'hB400, 4);
      expect_pkt(16'hB100, 4);
      wait_idle("rr_after_p2");

      // All ports busy from rr_ptr 0: fixed 5-cycle grant pattern.
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int p = 0; p < N; p++) load(p, 8, 16'h3000 + DW'(p * 256));
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < N; p++) begin
            eg = 5'b00001 << p;
            exp_grants.push_back(eg);
            expect_pkt(16'h3000 + DW'(p * 256 + r * 4), 4);
         end
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         eg = ((k % 5) == 4) ? 5'b00000 : (5'b00001 << ((k / 5) % 5));
         check("all_grant", grant_o, eg);
         check("all_read", buf_read_o, eg);
      end
      wait_idle("all_ports");

      // Back-pressure on port 1 after its first flit.
      load(1, 4, 16'h4100);
      exp_grants.push_back(5'b00010);
      expect_pkt(16'h4100, 4);
      @(negedge clk);
      check("bp_read1", buf_read_o, 5'b00010);
      @(negedge clk);
      check("bp_read2", buf_read_o, 5'b00010);
      out_ready_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("bp_read", buf_read_o, 0);
         check("bp_valid", out_valid_o, 0);
         check("bp_grant", grant_o, 5'b00010);
         check("bp_busy", busy_o, 1);
      end
      out_ready_i = 1'b1;
      wait_idle("backpressure");

      // Port 3 packet moves rr_ptr to 4 so port 0 wins next.
      load(3, 4, 16'h5300);
      exp_grants.push_back(5'b01000);
      expect_pkt(16'h5300, 4);
      wait_idle("p3_pre");

      // Port 0 runs dry mid-packet while port 3 waits.
      load(0, 2, 16'h5000);
      load(3, 4, 16'h5310);
      exp_grants.push_back(5'b00001);
      exp_grants.push_back(5'b01000);
      expect_pkt(16'h5000, 4);
      expect_pkt(16'h5310, 4);
      repeat (2) @(negedge clk);
      repeat (4) begin
         @(negedge clk);
         check("dry_grant", grant_o, 5'b00001);
         check("dry_busy", busy_o, 1);
         check("dry_read", buf_read_o, 0);
      end
      load(0, 2, 16'h5002);
      wait_idle("refill");

      // Port 1 sends one flit then starves; port 2 is waiting.
      load(1, 1, 16'h6100);
      load(2, 4, 16'h6200);
      exp_grants.push_back(5'b00010);
      exp_grants.push_back(5'b00100);
`ifdef ARB_LOCK_TIMEOUT_EN
      expect_pkt(16'h6100, 1);
      expect_pkt(16'h6200, 4);
      aborts = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (abort_o) begin
            aborts++;
            check("abort_grant", grant_o, 0);
         end
      end
      check("abort_pulses", aborts, 1);
      wait_idle("timeout");
`else
      expect_pkt(16'h6100, 4);
      expect_pkt(16'h6200, 4);
      aborts = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (abort_o) aborts++;
         check("hold_grant", grant_o, 5'b00010);
      end
      check("no_abort", aborts, 0);
      load(1, 3, 16'h6101);
      wait_idle("hold");
`endif

      check("flits_left", exp_flits.size(), 0);
      check("grants_left", exp_grants.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
